// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag-bit positions and the flag-word width.
// Imported by the result stage and by anything that decodes its flag output.
package alu_pkg;

  localparam int FLAG_W = 4;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  // Flag word layout is {C,Z,N,P}.
  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_P = 0;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid/wr_ready   write handshake; wr_ready = (count < DEPTH)
//   wr_data             entry to store
//   rd_valid/rd_ready   read handshake; rd_valid = (count != 0)
//   rd_data             head entry, or the last entry read when empty
//   count               current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap for free.
module alu_result_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push, pop;

  // wr_ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign wr_ready = (count_q < CW'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign count    = count_q;

  // When empty, show the entry most recently read rather than a stale slot.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : last_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage of the ALU: selects the result for the opcode,
// derives {C,Z,N,P}, and buffers result+flags in a FIFO for the consumer.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake (in_ready = count < DEPTH)
//   in_op                       0 AND, 1 OR, 2 XOR, 3 ADD
//   in_and/in_or/in_xor/in_sum  candidate results; in_carry = adder carry-out
//   out_valid/out_ready         downstream handshake (out_valid = count != 0)
//   out_data/out_flags          head result and its flags {C,Z,N,P}
//   count                       FIFO occupancy
//   op_count                    accepted operations, saturating at 16'hFFFF
//
// Handshake: a transfer happens on a rising edge exactly when valid and ready
// are both high on that side; valid may be asserted regardless of ready, and
// nothing is consumed or stored on an edge where either is low.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [WIDTH-1:0]       in_and,
  input  logic [WIDTH-1:0]       in_or,
  input  logic [WIDTH-1:0]       in_xor,
  input  logic [WIDTH-1:0]       in_sum,
  input  logic                   in_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [FLAG_W-1:0]      out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            op_count
);

  logic [WIDTH-1:0]        result;
  logic [FLAG_W-1:0]       flags;
  logic [WIDTH+FLAG_W-1:0] head;
  logic                    push;
  logic [15:0]             op_count_q, op_count_d;

  always_comb begin
    result = in_and;
    case (in_op)
      OP_AND:  result = in_and;
      OP_OR:   result = in_or;
      OP_XOR:  result = in_xor;
      OP_ADD:  result = in_sum;
      default: result = in_and;
    endcase
  end

  always_comb begin
    flags        = '0;
    // Carry is meaningful only for the adder; logic ops always report C=0.
    flags[FLG_C] = (in_op == OP_ADD) && in_carry;
    flags[FLG_Z] = (result == '0);
    flags[FLG_N] = result[WIDTH-1];
    flags[FLG_P] = ^result;
  end

  assign push = in_valid && in_ready;

  always_comb begin
    op_count_d = op_count_q;
    if (push && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;

  alu_result_fifo #(
    .WIDTH (WIDTH + FLAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({result, flags}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head),
    .count    (count)
  );

  assign out_data  = head[WIDTH+FLAG_W-1:FLAG_W];
  assign out_flags = head[FLAG_W-1:0];

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vectors with hand-computed results.
module tb_alu_result_stage;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_and, in_or, in_xor, in_sum;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_flags;
  logic [2:0]       count;
  logic [15:0]      op_count;

  logic [WIDTH+3:0] exp_q[$];
  int               n_vec;
  int               n_fail;
  logic             stream_on;

  // Directed vectors: opcode, selected value, carry-in, hand-derived {C,Z,N,P}.
  logic [1:0]       v_op  [10];
  logic [7:0]       v_val [10];
  logic             v_c   [10];
  logic [3:0]       v_flg [10];

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_and    (in_and),
    .in_or     (in_or),
    .in_xor    (in_xor),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .count     (count),
    .op_count  (op_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_count",     count,     0);
    chk("rst_op_count",  op_count,  0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_flags", out_flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Only the selected bus carries the value; the others carry a different
  // pattern so a wrong select shows up in the data.
  task automatic set_bus(input logic [1:0] op, input logic [7:0] val, input logic c);
    in_op    = op;
    in_carry = c;
    in_and   = (op == 2'd0) ? val : val ^ 8'h3C;
    in_or    = (op == 2'd1) ? val : val ^ 8'hC3;
    in_xor   = (op == 2'd2) ? val : val ^ 8'h5A;
    in_sum   = (op == 2'd3) ? val : val ^ 8'hA5;
  endtask

  // Call between edges. Holds the op until accepted, queues its expected word.
  task automatic drive_op(input logic [1:0] op, input logic [7:0] val, input logic c,
                          input logic [3:0] exp_flg);
    bit done;
    done = 0;
    set_bus(op, val, c);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        exp_q.push_back({val, exp_flg});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d val %0h never accepted", op, val);
    end
  endtask

  task automatic drive_vec(input int i);
    drive_op(v_op[i], v_val[i], v_c[i], v_flg[i]);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled mid-cycle: valid&&ready here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h/%0h, expected nothing", out_data, out_flags);
      end else begin
        logic [WIDTH+3:0] e;
        e = exp_q.pop_front();
        chk("out_data",  out_data,  e[WIDTH+3:4]);
        chk("out_flags", out_flags, e[3:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_fail = 0;
    stream_on = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_bus(2'd0, 8'h00, 1'b0);

    v_op[0]=2'd0; v_val[0]=8'h0F; v_c[0]=1; v_flg[0]=4'b0000;
    v_op[1]=2'd1; v_val[1]=8'h80; v_c[1]=0; v_flg[1]=4'b0011;
    v_op[2]=2'd2; v_val[2]=8'h00; v_c[2]=1; v_flg[2]=4'b0100;
    v_op[3]=2'd3; v_val[3]=8'hFF; v_c[3]=1; v_flg[3]=4'b1010;
    v_op[4]=2'd3; v_val[4]=8'h01; v_c[4]=0; v_flg[4]=4'b0001;
    v_op[5]=2'd0; v_val[5]=8'hFE; v_c[5]=0; v_flg[5]=4'b0011;
    v_op[6]=2'd1; v_val[6]=8'h7F; v_c[6]=1; v_flg[6]=4'b0001;
    v_op[7]=2'd2; v_val[7]=8'hC3; v_c[7]=0; v_flg[7]=4'b0010;
    v_op[8]=2'd3; v_val[8]=8'h00; v_c[8]=0; v_flg[8]=4'b0100;
    v_op[9]=2'd3; v_val[9]=8'h55; v_c[9]=1; v_flg[9]=4'b1000;

    #3;
    apply_reset();

    // ADD of zero with carry: C=1, Z=1 -> 4'b1100, visible one cycle later.
    drive_op(2'd3, 8'h00, 1'b1, 4'b1100);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data",  out_data,  8'h00);
    chk("t1_out_flags", out_flags, 4'b1100);
    chk("t1_count",     count,     1);
    chk("t1_op_count",  op_count,  1);

    // XOR A5 with carry ignored: N=1, P=0 -> 4'b0010; push and pop together.
    out_ready = 1'b1;
    drive_op(2'd2, 8'hA5, 1'b1, 4'b0010);
    chk("t2_count",     count,     1);
    chk("t2_out_data",  out_data,  8'hA5);
    chk("t2_out_flags", out_flags, 4'b0010);
    chk("t2_op_count",  op_count,  2);
    wait_drain();
    chk("t2_empty_hold_data", out_data, 8'hA5);

    // Fill to DEPTH, then a fifth offer must be refused.
    apply_reset();
    for (int i = 0; i < 4; i++) drive_vec(i);
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_count_full",    count,    4);
    set_bus(v_op[4], v_val[4], v_c[4]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_count_refused",    count,    4);
    chk("t3_op_count_refused", op_count, 4);

    // Full with in_valid and out_ready: pop only.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_count_pop_only", count,    3);
    chk("t4_in_ready",       in_ready, 1);
    chk("t4_op_count",       op_count, 4);
    // Now push and pop in the same cycle.
    exp_q.push_back({v_val[4], v_flg[4]});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t4_count_push_pop", count,    3);
    chk("t4_op_count_push",  op_count, 5);
    wait_drain();
    chk("t4_count_empty", count, 0);

    // Stream all vectors with a random consumer across pointer wrap.
    apply_reset();
    stream_on = 1'b1;
    fork
      begin
        while (stream_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 10; i++) drive_vec(i);
    stream_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
    chk("t5_op_count", op_count, 10);
    chk("t5_count",    count,    0);

    // Asynchronous reset with two entries held.
    apply_reset();
    drive_vec(5);
    drive_vec(6);
    chk("t6_count_before", count, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_count",     count,     0);
    chk("t6_in_ready",  in_ready,  1);
    chk("t6_out_data",  out_data,  0);
    chk("t6_out_flags", out_flags, 0);
    chk("t6_op_count",  op_count,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    drive_vec(7);
    chk("t6_new_valid",   out_valid, 1);
    chk("t6_new_data",    out_data,  8'hC3);
    chk("t6_new_flags",   out_flags, 4'b0010);
    chk("t6_new_count",   count,     1);
    chk("t6_new_opcount", op_count,  1);
    out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage of the 8-bit ALU. It sits directly downstream of the bitwise gate blocks (AND/OR/XOR) and the adder. It selects one result per accepted operation by opcode and computes status flags. Each result+flags word is buffered in a small FIFO and presented to the consumer over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, datapath width; results and flags are computed at this width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream offers an operation this cycle.
- in_ready  output  1  stage can accept; high iff count < DEPTH.
- in_op  input  2  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD.
- in_and, in_or, in_xor, in_sum  input  WIDTH  results from the gate blocks and the adder.
- in_carry  input  1  adder carry-out.
- out_valid  output  1  head entry is valid; high iff count != 0.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_data  output  WIDTH  head result.
- out_flags  output  4  head flags {C,Z,N,P}, with bit 3 = C.
- count  output  $clog2(DEPTH)+1  current occupancy.
- op_count  output  16  number of accepted operations, saturating.

## Operation
- Push occurs when in_valid && in_ready.
  - Result: in_op 0→in_and, 1→in_or, 2→in_xor, 3→in_sum.
  - C = in_carry if in_op==3, else 0.
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - P = XOR-reduction of result (1 = odd number of ones).
- Pop occurs when out_valid && out_ready. The head advances, and out_data/out_flags are undefined-free: they show the next entry, or hold the last value when empty.
- count updates:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push.
- When empty, out_valid=0, so a pop cannot occur; a push in that cycle is stored normally.
- op_count increments on every push and saturates at 16'hFFFF (no wrap).
- Inputs other than in_valid are ignored when no push occurs. in_op/data may change freely while in_valid=0.
- Reset, including asynchronous assertion mid-transfer:
  - count=0, pointers=0, op_count=0.
  - out_valid=0, in_ready=1 (while rst_n is low and after release).
  - out_data=0, out_flags=0.
  - All FIFO contents are discarded.

## Timing
- Latency: an operation pushed at edge k is visible on out_valid/out_data/out_flags after edge k (one cycle), including the empty-FIFO case. There is no fall-through bypass.
- Throughput: one push and one pop per cycle sustained when not full.
- Flags are computed combinationally from the inputs and registered with the result; out_flags always corresponds to out_data.
- Transfer on either side completes only at the rising edge where valid and ready are both high.
- The first push is possible at the first clk edge after rst_n deasserts.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_ADD=2'd3;
  - flag bit indices FLG_C=3, FLG_Z=2, FLG_N=1, FLG_P=0;
  - the flag width 4.
- Sub-module alu_result_fifo: a generic WIDTH+4-bit synchronous FIFO with DEPTH entries, count, and asynchronous active-low reset. The top level holds the select, the flag generation, and op_count.

## Test plan
- Reset, then push op=3, sum=8'h00, carry=1 → next cycle out_valid=1, out_data=8'h00, out_flags=4'b1100, count=1, op_count=1.
- Push XOR with in_xor=8'hA5 and in_carry=1 → out_data=8'hA5, flags C=0, Z=0, N=1, P=0 (four ones), i.e. 4'b0010.
- Push 4 entries with out_ready=0 → in_ready=0 and count=4. A 5th in_valid is not accepted and op_count stays 4. Then out_ready=1 pops them in FIFO order over 4 cycles.
- Full FIFO with in_valid=1 and out_ready=1 simultaneously → pop only, count=3. On the next cycle, push and pop together and count stays 3.
- Stream 10 operations through DEPTH=4 with a randomized out_ready → output order matches input order across pointer wrap.
- Assert rst_n low mid-stream with count=2 → out_valid=0, count=0, in_ready=1 immediately. After release, the first new push appears one cycle later.
